// File: rtl/fetch_unit.sv
// fetch_unit: MIPS F stage. Owns the PC, drives imem reads, and buffers up to two fetched words.
// Define FETCH_ADEL_EN to enable fetch address-error detection against IM_BASE/IM_BYTES.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef FETCH_ADEL_EN
    ,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_BYTES = 32'h0000_4000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        block,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_O,
    output logic [31:0] pc4_O,
    output logic [31:0] im_O,
    output logic        valid_O,
    output logic        adel_O
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      drop_addr_q, drop_addr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0][31:0] qpc_q, qpc_d;
    logic [1:0][31:0] qins_q, qins_d;

    logic             consume;
    logic             push;
    logic             issue_ok;
    logic [1:0]       cnt_pop;
    logic [31:0]      push_ins;
    logic [31:0]      fetch_addr;
    logic [31:0]      pc_plus4;

`ifdef FETCH_ADEL_EN
    logic [1:0]       qadel_q, qadel_d;
    logic             halt_q, halt_d;
    logic             push_adel;
    logic             bad_addr;
    logic [31:0]      win_off;
`endif

    // Entry 0 is always the queue head.
    always_comb begin
        valid_O = (cnt_q != 2'd0);
        pc_O    = valid_O ? qpc_q[0] : pc_q;
        pc4_O   = pc_O + 32'd4;
        im_O    = valid_O ? qins_q[0] : 32'h0;
`ifdef FETCH_ADEL_EN
        adel_O  = valid_O & qadel_q[0];
`else
        adel_O  = 1'b0;
`endif
    end

    always_comb begin
        consume    = valid_O & ~block & ~redirect;
        cnt_pop    = cnt_q - {1'b0, consume};
        pc_plus4   = pc_q + 32'd4;
        fetch_addr = {pc_q[31:2], 2'b00};
`ifdef FETCH_ADEL_EN
        win_off    = pc_q - IM_BASE;
        bad_addr   = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE)
                     || (win_off >= IM_BYTES);
        issue_ok   = (cnt_pop <= 2'd1) & ~halt_q;
        halt_d     = halt_q;
        push_adel  = 1'b0;
`else
        issue_ok   = (cnt_pop <= 2'd1);
`endif
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        imem_req    = 1'b0;
        imem_addr   = fetch_addr;
        push        = 1'b0;
        push_ins    = imem_rdata;

        unique case (state_q)
            IDLE: begin
                if (issue_ok) state_d = REQ;
            end
            REQ: begin
`ifdef FETCH_ADEL_EN
                if (bad_addr) begin
                    push      = 1'b1;
                    push_ins  = 32'h0;
                    push_adel = 1'b1;
                    halt_d    = 1'b1;
                    state_d   = IDLE;
                end else
`endif
                begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        push    = 1'b1;
                        pc_d    = pc_plus4;
                        // Next request only if a slot stays free after this push.
                        state_d = (cnt_pop == 2'd0) ? REQ : IDLE;
                    end
                end
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
                if (imem_ready) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        // An unanswered request must still complete its handshake, so park in DROP.
        if (redirect) begin
            push        = 1'b0;
            pc_d        = redirect_pc;
            drop_addr_d = imem_addr;
            state_d     = (imem_req && !imem_ready) ? DROP : REQ;
`ifdef FETCH_ADEL_EN
            push_adel   = 1'b0;
            halt_d      = 1'b0;
`endif
        end
    end

    always_comb begin
        qpc_d  = qpc_q;
        qins_d = qins_q;
`ifdef FETCH_ADEL_EN
        qadel_d = qadel_q;
`endif
        cnt_d  = cnt_q;
        if (redirect) begin
            cnt_d = 2'd0;
        end else begin
            if (consume) begin
                qpc_d[0]  = qpc_q[1];
                qins_d[0] = qins_q[1];
`ifdef FETCH_ADEL_EN
                qadel_d[0] = qadel_q[1];
`endif
            end
            if (push) begin
                qpc_d[cnt_pop[0]]  = pc_q;
                qins_d[cnt_pop[0]] = push_ins;
`ifdef FETCH_ADEL_EN
                qadel_d[cnt_pop[0]] = push_adel;
`endif
            end
            cnt_d = cnt_pop + {1'b0, push};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            cnt_q       <= 2'd0;
            qpc_q       <= '0;
            qins_q      <= '0;
`ifdef FETCH_ADEL_EN
            qadel_q     <= 2'b00;
            halt_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            cnt_q       <= cnt_d;
            qpc_q       <= qpc_d;
            qins_q      <= qins_d;
`ifdef FETCH_ADEL_EN
            qadel_q     <= qadel_d;
            halt_q      <= halt_d;
`endif
        end
    end

endmodule
